regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
Shares the single write port of the processor register bank (N registers x W bits, register 0 hard-wired to zero on reads) among R independent requesters using round-robin arbitration with a req/gnt handshake. Also contains a clear sequencer that, on command, walks registers 1..N-1 and writes zero to each. Sits directly in front of the register bank's write-enable, write-address and write-data inputs. Read ports are not touched.

Parameters:
N, 32, number of registers in the bank; the address width is fixed at 5 bits, so N <= 32.
W, 16, data width of each register.
R, 4, number of write requesters, 2..8.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low; state clears while low.
req  input  R  write request per requester; held until granted.
req_addr  input  R*5  destination address, requester i in bits [5i+4:5i].
req_data  input  R*W  write data, requester i in bits [Wi+W-1:Wi].
gnt  output  R  one-hot grant, combinational, at most one bit high.
clr_start  input  1  start the clear sequence; sampled in IDLE only.
clr_busy  output  1  high while state != IDLE.
clr_done  output  1  one-cycle pulse at the end of the clear sequence.
wr_en  output  1  registered write enable to the bank.
wr_addr  output  5  registered write address to the bank.
wr_data  output  W  registered write data to the bank.

Behaviour:
- Reset (rst low, async): state=IDLE, rr_ptr=R-1, clear counter=1, wr_en=0, wr_addr=0, wr_data=0, clr_done=0. gnt=0 and clr_busy=0 follow from the reset state.
- FSM states: IDLE, CLEAR, DONE.
- IDLE with clr_start=0: arbitrate. Search order is rr_ptr+1, rr_ptr+2, ... mod R. The first active req wins and its gnt bit goes high in the same cycle.
- Grant handshake: the requester sees gnt at the clock edge and may drop req or present a new request in the next cycle. One grant per cycle, so throughput is 1 write per cycle.
- On a grant edge: rr_ptr <= winner index; wr_addr/wr_data <= the winner's payload; wr_en <= 1 if the payload address != 0.
- A write to address 0 is still granted but discarded: wr_en <= 0 and wr_addr/wr_data are loaded anyway.
- No active req: gnt=0, wr_en <= 0, rr_ptr unchanged.
- Latency: request to wr_en is 1 cycle; the bank commits at the following edge.
- IDLE with clr_start=1: clr_start has priority over requests. gnt=0 this cycle, wr_en <= 0, counter <= 1, next state CLEAR. Pending requests wait.
- CLEAR: gnt=0 always. Each cycle: wr_en <= 1, wr_addr <= counter, wr_data <= 0, counter <= counter+1.
- CLEAR to DONE: when counter == N-1, that write is issued and next state is DONE.
- DONE (1 cycle): clr_done=1; the output registers hold the address N-1 write. gnt=0, wr_en <= 0, next state IDLE.
- clr_start is ignored in CLEAR and DONE.
- Total clear sequence: N-1 consecutive write cycles.
- clr_busy=1 in CLEAR and DONE.
- rr_ptr is not modified by the clear sequence.
- Reset mid-clear or mid-grant: outputs are zeroed immediately. No partial write is completed; any in-flight grant is lost, and requesters must re-request.
- Requester payload is don't-care when its req=0.
- Fairness: with all R requests held continuously, each requester is granted exactly once every R cycles.

Test Plan:
- Reset: drive rst=0 mid-traffic with req=4'b1111 -> gnt=0, wr_en=0, wr_addr=0, clr_busy=0 asynchronously. After release, the first grant goes to requester 0.
- Single requester: req[2]=1, addr=5, data=16'hBEEF -> gnt=4'b0100 in the same cycle. Next cycle wr_en=1, wr_addr=5, wr_data=16'hBEEF. Following cycle wr_en=0 once req is dropped.
- Round robin: req=4'b1111 held for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001, ...; wr_en high continuously from cycle 2.
- Address 0: req[1]=1, addr=0, data=16'h1234 -> gnt[1]=1, wr_en stays 0. Then req[1]=1, addr=31 -> wr_en=1, wr_addr=31.
- Clear: pulse clr_start in IDLE with req[3]=1 held -> gnt=0 throughout. wr_en=1 with wr_addr 1..31 and wr_data=0 on 31 consecutive cycles. clr_done=1 together with wr_addr=31. After returning to IDLE, req[3] is granted.
- Reset during CLEAR at wr_addr=10 -> wr_en=0 and state IDLE immediately. A new clr_start then restarts the sequence from address 1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-bank write port, plus a clear
// sequencer that writes zero to registers 1..N-1 on command.
module regfile_write_arbiter #(
  parameter int N = 32,
  parameter int W = 16,
  parameter int R = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req,
  input  logic [R*5-1:0]   req_addr,
  input  logic [R*W-1:0]   req_data,
  output logic [R-1:0]     gnt,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic [W-1:0]     wr_data
);

  localparam int          PW        = (R > 1) ? $clog2(R) : 1;
  localparam logic [4:0]  LAST_ADDR = 5'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           wr_en_q, wr_en_d;
  logic [4:0]     wr_addr_q, wr_addr_d;
  logic [W-1:0]   wr_data_q, wr_data_d;
  logic           clr_done_q, clr_done_d;

  logic           found;
  int unsigned    win_i;
  logic [PW-1:0]  win_idx;
  logic [4:0]     win_addr;
  logic [W-1:0]   win_data;
  logic           arb_en;

  // Search starts one past the last winner so every requester gets its turn.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    win_i = 0;
    for (int k = 1; k <= R; k++) begin
      if (!found && req[(int'(rr_ptr_q) + k) % R]) begin
        found = 1'b1;
        win_i = (int'(rr_ptr_q) + k) % R;
      end
    end
  end

  assign win_idx  = PW'(win_i);
  assign win_addr = req_addr[5*win_i +: 5];
  assign win_data = req_data[W*win_i +: W];

  // Grants only exist in IDLE when no clear is being started; reset blanks them.
  assign arb_en = rst && (state_q == ST_IDLE) && !clr_start;

  always_comb begin
    gnt = '0;
    if (arb_en && found) begin
      gnt[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    clr_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          cnt_d   = 5'd1;
          state_d = ST_CLEAR;
        end else if (found) begin
          rr_ptr_d  = win_idx;
          wr_addr_d = win_addr;
          wr_data_d = win_data;
          // Writes to register 0 are granted but never reach the bank.
          wr_en_d   = (win_addr != 5'd0);
        end
      end
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = '0;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == LAST_ADDR) begin
          state_d    = ST_DONE;
          clr_done_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= PW'(R - 1);
      cnt_q      <= 5'd1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign clr_busy = (state_q != ST_IDLE);
  assign clr_done = clr_done_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule
